// File: rtl/sram_phase_sequencer.sv
`timescale 1ns/1ps
// Owner of the decoder's single SRAM port: steps UART load -> M2 -> M1 -> display,
// grants the bus to one client per phase and reports per-phase cycle counts.
module sram_phase_sequencer #(
  parameter int SKIP_M2        = 0,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int CNT_W          = 22
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             run_i,
  input  logic             uart_done_i,
  input  logic             m1_endF_i,
  input  logic             m2_endF_i,
  output logic             m1_startF_o,
  output logic             m2_startF_o,
  input  logic [71:0]      cli_addr_i,
  input  logic [63:0]      cli_wdata_i,
  input  logic [3:0]       cli_we_n_i,
  output logic [17:0]      SRAM_address_o,
  output logic [15:0]      SRAM_write_data_o,
  output logic             SRAM_we_n_o,
  output logic [1:0]       grant_o,
  output logic [3:0]       phase_o,
  output logic [CNT_W-1:0] phase_cycles_o,
  output logic             busy_o,
  output logic             error_o
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_UART    = 4'd1,
    S_GAP_A   = 4'd2,
    S_M2_GO   = 4'd3,
    S_M2      = 4'd4,
    S_GAP_B   = 4'd5,
    S_M1_GO   = 4'd6,
    S_M1      = 4'd7,
    S_GAP_C   = 4'd8,
    S_DISPLAY = 4'd9
  } state_t;

  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic             run_q;
  logic             error_q, error_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0] pc_q, pc_d;
  logic             active, we_force;

  logic [17:0] addr_a  [4];
  logic [15:0] wdata_a [4];
  logic        we_a    [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cli
      assign addr_a[gi]  = cli_addr_i[gi*18 +: 18];
      assign wdata_a[gi] = cli_wdata_i[gi*16 +: 16];
      assign we_a[gi]    = cli_we_n_i[gi];
    end
  endgenerate

  assign active  = (state_q == S_UART) || (state_q == S_M2) || (state_q == S_M1);
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    error_d = error_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    // End flags are only honoured in the owning client's active state.
    case (state_q)
      S_IDLE: begin
        if (run_i && !run_q) begin
          state_d = S_UART;
          error_d = 1'b0;
        end
      end
      S_UART:    if (uart_done_i) state_d = S_GAP_A;
      S_GAP_A:   state_d = (SKIP_M2 != 0) ? S_M1_GO : S_M2_GO;
      S_M2_GO:   state_d = S_M2;
      S_M2:      if (m2_endF_i) state_d = S_GAP_B;
      S_GAP_B:   state_d = S_M1_GO;
      S_M1_GO:   state_d = S_M1;
      S_M1:      if (m1_endF_i) state_d = S_GAP_C;
      S_GAP_C:   state_d = S_DISPLAY;
      S_DISPLAY: if (!run_i) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    // A completing phase wins over a timeout landing on the same cycle.
    if (active && (state_d == state_q) && (cnt_q == TO_LIM)) begin
      state_d = S_IDLE;
      error_d = 1'b1;
    end
    if (state_d != state_q) begin
      cnt_d = '0;
      if (active) pc_d = cnt_inc;
    end else if (active) begin
      cnt_d = cnt_inc;
    end
    // Gaps keep the outgoing owner on the bus with writes blocked.
    case (state_d)
      S_IDLE, S_DISPLAY: grant_d = 2'd3;
      S_UART:            grant_d = 2'd0;
      S_M2_GO, S_M2:     grant_d = 2'd1;
      S_M1_GO, S_M1:     grant_d = 2'd2;
      default:           grant_d = grant_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      grant_q <= 2'd3;
      run_q   <= 1'b0;
      error_q <= 1'b0;
      cnt_q   <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      run_q   <= run_i;
      error_q <= error_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
    end
  end

  assign we_force = !((state_q == S_UART) || (state_q == S_M2_GO) || (state_q == S_M2) ||
                      (state_q == S_M1_GO) || (state_q == S_M1));

  assign SRAM_address_o    = addr_a[grant_q];
  assign SRAM_write_data_o = wdata_a[grant_q];
  assign SRAM_we_n_o       = we_force ? 1'b1 : we_a[grant_q];
  assign grant_o           = grant_q;
  assign phase_o           = state_q;
  assign phase_cycles_o    = pc_q;
  assign busy_o            = (state_q != S_IDLE);
  assign error_o           = error_q;
  assign m2_startF_o       = (state_q == S_M2_GO);
  assign m1_startF_o       = (state_q == S_M1_GO);

endmodule

// File: tb/tb_sram_phase_sequencer.sv
`timescale 1ns/1ps
// Scoreboard bench: instance A runs the full flow, instance B skips M2 and has a short timeout.
module tb_sram_phase_sequencer;

  localparam int CNT_W = 22;
  localparam logic [3:0] P_IDLE = 4'd0, P_UART = 4'd1, P_GAP_A = 4'd2, P_M2_GO = 4'd3,
                         P_M2 = 4'd4, P_GAP_B = 4'd5, P_M1_GO = 4'd6, P_M1 = 4'd7,
                         P_GAP_C = 4'd8, P_DISPLAY = 4'd9;

  typedef struct {
    logic [3:0]  phase;
    logic [1:0]  grant;
    int          pc;
    logic        err;
    logic        busy;
    logic        we_n;
    logic [17:0] addr;
    logic [15:0] wdata;
    int          dur;
  } exp_t;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic [1:0] rst, run, uart_done, m1_end, m2_end;
  logic [1:0] m1_start, m2_start, we_n_o, busy, err;
  logic [1:0][17:0]      addr_o;
  logic [1:0][15:0]      wdata_o;
  logic [1:0][1:0]       grant;
  logic [1:0][3:0]       phase;
  logic [1:0][CNT_W-1:0] pcyc;
  logic [71:0] cli_addr;
  logic [63:0] cli_wdata;
  logic [3:0]  cli_we_n;

  logic [17:0] addr_tab  [4];
  logic [15:0] wdata_tab [4];

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic mon_en   = 1'b0;
  exp_t exp_q [2][$];
  int   m1_cnt [2];
  int   m2_cnt [2];
  logic g1_seen [2];

  always @(posedge clk) cyc <= cyc + 1;

  sram_phase_sequencer #(.SKIP_M2(0), .TIMEOUT_CYCLES(200), .CNT_W(CNT_W)) u_a (
    .clk_i(clk), .reset_i(rst[0]), .run_i(run[0]), .uart_done_i(uart_done[0]),
    .m1_endF_i(m1_end[0]), .m2_endF_i(m2_end[0]),
    .m1_startF_o(m1_start[0]), .m2_startF_o(m2_start[0]),
    .cli_addr_i(cli_addr), .cli_wdata_i(cli_wdata), .cli_we_n_i(cli_we_n),
    .SRAM_address_o(addr_o[0]), .SRAM_write_data_o(wdata_o[0]), .SRAM_we_n_o(we_n_o[0]),
    .grant_o(grant[0]), .phase_o(phase[0]), .phase_cycles_o(pcyc[0]),
    .busy_o(busy[0]), .error_o(err[0]));

  sram_phase_sequencer #(.SKIP_M2(1), .TIMEOUT_CYCLES(64), .CNT_W(CNT_W)) u_b (
    .clk_i(clk), .reset_i(rst[1]), .run_i(run[1]), .uart_done_i(uart_done[1]),
    .m1_endF_i(m1_end[1]), .m2_endF_i(m2_end[1]),
    .m1_startF_o(m1_start[1]), .m2_startF_o(m2_start[1]),
    .cli_addr_i(cli_addr), .cli_wdata_i(cli_wdata), .cli_we_n_i(cli_we_n),
    .SRAM_address_o(addr_o[1]), .SRAM_write_data_o(wdata_o[1]), .SRAM_we_n_o(we_n_o[1]),
    .grant_o(grant[1]), .phase_o(phase[1]), .phase_cycles_o(pcyc[1]),
    .busy_o(busy[1]), .error_o(err[1]));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Expected bus view: VGA and gap/idle states never write; otherwise owner's signals pass through.
  function automatic exp_t mk(input logic [3:0] ph, input logic [1:0] g, input int pc,
                              input logic e, input int dur);
    exp_t r;
    r.phase = ph; r.grant = g; r.pc = pc; r.err = e; r.dur = dur;
    r.busy  = (ph != P_IDLE);
    r.addr  = addr_tab[g];
    r.wdata = wdata_tab[g];
    r.we_n  = (ph == P_UART || ph == P_M2_GO || ph == P_M2 || ph == P_M1_GO || ph == P_M1)
              ? cli_we_n[g] : 1'b1;
    return r;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_mon
      initial begin
        logic [3:0] prev;
        int last_cyc, w1, w2, d;
        exp_t e;
        string tag;
        tag = (gi == 0) ? "A" : "B";
        prev = P_IDLE; w1 = 0; w2 = 0;
        m1_cnt[gi] = 0; m2_cnt[gi] = 0; g1_seen[gi] = 1'b0;
        wait (mon_en);
        last_cyc = cyc;
        forever begin
          @(negedge clk);
          if (grant[gi] == 2'd1) g1_seen[gi] = 1'b1;
          if (m2_start[gi]) w2++;
          else if (w2 != 0) begin
            check($sformatf("%s_m2_start_width", tag), w2, 1); m2_cnt[gi]++; w2 = 0;
          end
          if (m1_start[gi]) w1++;
          else if (w1 != 0) begin
            check($sformatf("%s_m1_start_width", tag), w1, 1); m1_cnt[gi]++; w1 = 0;
          end
          if (phase[gi] != prev) begin
            d = cyc - last_cyc;
            $display("[%s] cyc=%0d phase=%0d grant=%0d phase_cycles=%0d err=%0d we_n=%0d addr=%0d dur=%0d",
                     tag, cyc, phase[gi], grant[gi], pcyc[gi], err[gi], we_n_o[gi], addr_o[gi], d);
            check($sformatf("%s_event_expected", tag), (exp_q[gi].size() != 0), 1);
            if (exp_q[gi].size() != 0) begin
              e = exp_q[gi].pop_front();
              check($sformatf("%s_phase", tag), phase[gi], e.phase);
              check($sformatf("%s_grant_p%0d", tag, e.phase), grant[gi], e.grant);
              check($sformatf("%s_phase_cycles_p%0d", tag, e.phase), pcyc[gi], e.pc);
              check($sformatf("%s_error_p%0d", tag, e.phase), err[gi], e.err);
              check($sformatf("%s_busy_p%0d", tag, e.phase), busy[gi], e.busy);
              check($sformatf("%s_we_n_p%0d", tag, e.phase), we_n_o[gi], e.we_n);
              check($sformatf("%s_addr_p%0d", tag, e.phase), addr_o[gi], e.addr);
              check($sformatf("%s_wdata_p%0d", tag, e.phase), wdata_o[gi], e.wdata);
              if (e.dur >= 0) check($sformatf("%s_dur_before_p%0d", tag, e.phase), d, e.dur);
            end
            prev = phase[gi];
            last_cyc = cyc;
          end
        end
      end
    end
  endgenerate

  task automatic push(input int inst, input exp_t e);
    exp_q[inst].push_back(e);
  endtask

  task automatic wait_phase(input int inst, input logic [3:0] p, input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (phase[inst] == p) break;
    end
    check($sformatf("wait_phase_%0d_inst%0d", p, inst), phase[inst], p);
  endtask

  task automatic pulse_after(input int inst, input logic [3:0] p, input int len, input int which);
    wait_phase(inst, p, 300);
    repeat (len - 1) @(negedge clk);
    case (which)
      0: uart_done[inst] = 1'b1;
      1: m2_end[inst] = 1'b1;
      default: m1_end[inst] = 1'b1;
    endcase
    @(negedge clk);
    uart_done[inst] = 1'b0; m2_end[inst] = 1'b0; m1_end[inst] = 1'b0;
  endtask

  task automatic finish_display(input int inst);
    wait_phase(inst, P_DISPLAY, 20);
    repeat (4) @(negedge clk);
    run[inst] = 1'b0;
    wait_phase(inst, P_IDLE, 20);
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    addr_tab[0] = 18'd17;     wdata_tab[0] = 16'hA001;
    addr_tab[1] = 18'd34;     wdata_tab[1] = 16'hB002;
    addr_tab[2] = 18'd146944; wdata_tab[2] = 16'hC003;
    addr_tab[3] = 18'd262143; wdata_tab[3] = 16'hD004;
    for (int i = 0; i < 4; i++) begin
      cli_addr[i*18 +: 18]  = addr_tab[i];
      cli_wdata[i*16 +: 16] = wdata_tab[i];
    end
    cli_we_n = 4'b0000;
    rst = 2'b11; run = 2'b00; uart_done = 2'b00; m1_end = 2'b00; m2_end = 2'b00;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset_phase_%0d", i), phase[i], P_IDLE);
      check($sformatf("reset_grant_%0d", i), grant[i], 3);
      check($sformatf("reset_we_n_%0d", i), we_n_o[i], 1);
      check($sformatf("reset_starts_%0d", i), {m1_start[i], m2_start[i]}, 0);
      check($sformatf("reset_error_%0d", i), err[i], 0);
      check($sformatf("reset_busy_%0d", i), busy[i], 0);
      check($sformatf("reset_pc_%0d", i), pcyc[i], 0);
    end
    rst = 2'b00;
    mon_en = 1'b1;

    // A: nominal flow 100/50/40
    push(0, mk(P_UART, 0, 0, 0, -1));   push(0, mk(P_GAP_A, 0, 100, 0, 100));
    push(0, mk(P_M2_GO, 1, 100, 0, 1)); push(0, mk(P_M2, 1, 100, 0, 1));
    push(0, mk(P_GAP_B, 1, 50, 0, 50)); push(0, mk(P_M1_GO, 2, 50, 0, 1));
    push(0, mk(P_M1, 2, 50, 0, 1));     push(0, mk(P_GAP_C, 2, 40, 0, 40));
    push(0, mk(P_DISPLAY, 3, 40, 0, 1)); push(0, mk(P_IDLE, 3, 40, 0, -1));
    run[0] = 1'b1;
    pulse_after(0, P_UART, 100, 0);
    pulse_after(0, P_M2, 50, 1);
    pulse_after(0, P_M1, 40, 2);
    finish_display(0);

    // A: spurious flags (m2_endF held over M2_GO, m1_endF/uart_done pulsed in M2)
    push(0, mk(P_UART, 0, 40, 0, -1));  push(0, mk(P_GAP_A, 0, 20, 0, 20));
    push(0, mk(P_M2_GO, 1, 20, 0, 1));  push(0, mk(P_M2, 1, 20, 0, 1));
    push(0, mk(P_GAP_B, 1, 30, 0, 30)); push(0, mk(P_M1_GO, 2, 30, 0, 1));
    push(0, mk(P_M1, 2, 30, 0, 1));     push(0, mk(P_GAP_C, 2, 25, 0, 25));
    push(0, mk(P_DISPLAY, 3, 25, 0, 1)); push(0, mk(P_IDLE, 3, 25, 0, -1));
    run[0] = 1'b1;
    pulse_after(0, P_UART, 20, 0);
    wait_phase(0, P_M2_GO, 20);
    m2_end[0] = 1'b1;
    @(negedge clk);
    m2_end[0] = 1'b0;
    check("A_still_in_m2_after_held_flag", phase[0], P_M2);
    repeat (3) @(negedge clk);
    m1_end[0] = 1'b1; uart_done[0] = 1'b1;
    @(negedge clk);
    m1_end[0] = 1'b0; uart_done[0] = 1'b0;
    repeat (25) @(negedge clk);
    m2_end[0] = 1'b1;
    @(negedge clk);
    m2_end[0] = 1'b0;
    pulse_after(0, P_M1, 25, 2);
    finish_display(0);

    // B: SKIP_M2 flow 10/20
    push(1, mk(P_UART, 0, 0, 0, -1));   push(1, mk(P_GAP_A, 0, 10, 0, 10));
    push(1, mk(P_M1_GO, 2, 10, 0, 1));  push(1, mk(P_M1, 2, 10, 0, 1));
    push(1, mk(P_GAP_C, 2, 20, 0, 20)); push(1, mk(P_DISPLAY, 3, 20, 0, 1));
    push(1, mk(P_IDLE, 3, 20, 0, -1));
    run[1] = 1'b1;
    pulse_after(1, P_UART, 10, 0);
    pulse_after(1, P_M1, 20, 2);
    finish_display(1);

    // B: timeout in M1 after 64 cycles
    push(1, mk(P_UART, 0, 20, 0, -1));  push(1, mk(P_GAP_A, 0, 10, 0, 10));
    push(1, mk(P_M1_GO, 2, 10, 0, 1));  push(1, mk(P_M1, 2, 10, 0, 1));
    push(1, mk(P_IDLE, 3, 64, 1, 64));
    run[1] = 1'b1;
    pulse_after(1, P_UART, 10, 0);
    wait_phase(1, P_M1, 20);
    wait_phase(1, P_IDLE, 100);
    repeat (5) @(negedge clk);
    check("B_error_sticky", err[1], 1);
    run[1] = 1'b0;
    @(negedge clk);

    // B: new run clears error, then reset mid-M1
    push(1, mk(P_UART, 0, 64, 0, -1));  push(1, mk(P_GAP_A, 0, 10, 0, 10));
    push(1, mk(P_M1_GO, 2, 10, 0, 1));  push(1, mk(P_M1, 2, 10, 0, 1));
    push(1, mk(P_IDLE, 3, 0, 0, 6));
    run[1] = 1'b1;
    pulse_after(1, P_UART, 10, 0);
    wait_phase(1, P_M1, 20);
    repeat (5) @(negedge clk);
    rst[1] = 1'b1; run[1] = 1'b0;
    @(negedge clk);
    rst[1] = 1'b0;
    check("B_reset_phase", phase[1], P_IDLE);
    check("B_reset_grant", grant[1], 3);
    check("B_reset_we_n", we_n_o[1], 1);
    check("B_reset_pc", pcyc[1], 0);
    repeat (20) @(negedge clk);

    check("A_m2_start_count", m2_cnt[0], 2);
    check("A_m1_start_count", m1_cnt[0], 2);
    check("B_m2_start_count", m2_cnt[1], 0);
    check("B_m1_start_count", m1_cnt[1], 3);
    check("B_grant1_seen", g1_seen[1], 0);
    check("A_queue_drained", exp_q[0].size(), 0);
    check("B_queue_drained", exp_q[1].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_phase_sequencer.md
Name: sram_phase_sequencer

Overview:
- Top-level controller for the decoder's single external SRAM port.
- Sequences the decode phases in order: UART image load, milestone 2 (IDCT/dequant), milestone 1 (upsample + colour-space conversion), then VGA display.
- Grants the SRAM to exactly one client per phase and muxes that client's address, write data and write enable onto the SRAM bus.
- Drives start pulses to the milestone engines, collects their end flags, enforces a per-phase cycle timeout and reports per-phase cycle counts.

Parameters:
- SKIP_M2, 0, when 1 the M2 phase is bypassed (image pre-loaded as YUV).
- TIMEOUT_CYCLES, 2000000, maximum cycles allowed in any active phase before abort.
- CNT_W, 22, width of the phase cycle counter.

Ports:
- Clock  in  1  system clock, 50 MHz.
- Reset  in  1  synchronous, active-high reset.
- run  in  1  level; a rising edge seen in S_IDLE starts a decode.
- uart_done  in  1  UART loader has written the whole image.
- m1_endF, m2_endF  in  1 each  end flags from milestone 1 / milestone 2.
- m1_startF, m2_startF  out  1 each  one-cycle start pulses.
- cli_addr[0..3]  in  18 each  SRAM address per client: 0=UART, 1=M2, 2=M1, 3=VGA.
- cli_wdata[0..3]  in  16 each  SRAM write data per client.
- cli_we_n[0..3]  in  1 each  SRAM write enable per client, active-low.
- SRAM_address  out  18  muxed SRAM address.
- SRAM_write_data  out  16  muxed SRAM write data.
- SRAM_we_n  out  1  muxed SRAM write enable, active-low.
- grant  out  2  index of the client currently owning the SRAM.
- phase  out  4  current state encoding.
- phase_cycles  out  CNT_W  cycle count of the last completed phase.
- busy  out  1  high in any state other than S_IDLE.
- error  out  1  sticky timeout flag.

Behaviour:
- Reset is synchronous and active-high. On reset:
  - state=S_IDLE, grant=3 (VGA), m1_startF=m2_startF=0, error=0, phase_cycles=0, busy=0.
  - Internal run_q=0 and cycle counter=0.
  - Reset asserted mid-phase aborts immediately; the start pulses are never re-issued.
- States and transitions:
  - S_IDLE: grant=3. Move to S_UART on run & ~run_q (rising edge). Clear error on entry to S_UART.
  - S_UART: grant=0. On uart_done go to S_GAP_A.
  - S_GAP_A: one cycle, SRAM_we_n forced 1. Next state is S_M2_GO, or S_M1_GO if SKIP_M2=1.
  - S_M2_GO: grant=1, m2_startF=1 for exactly this cycle, then S_M2.
  - S_M2: grant=1. On m2_endF go to S_GAP_B.
  - S_GAP_B: one cycle, SRAM_we_n forced 1, then S_M1_GO.
  - S_M1_GO: grant=2, m1_startF=1 for one cycle, then S_M1.
  - S_M1: grant=2. On m1_endF go to S_GAP_C.
  - S_GAP_C: one cycle, SRAM_we_n forced 1, then S_DISPLAY.
  - S_DISPLAY: grant=3. Stays here until run falls, then S_IDLE.
- Mux:
  - Combinational from the registered grant.
  - SRAM_we_n = cli_we_n[grant], except forced 1 in S_IDLE, S_DISPLAY and all S_GAP states (VGA is read-only).
  - Latency from client signals to the SRAM bus is 0 cycles.
- End flags: an end flag or uart_done from a client that is not the current owner is ignored. An end flag already high in a *_GO cycle is ignored; it is sampled only in the following active state.
- Cycle counter:
  - Clears on every state change and increments each cycle in S_UART, S_M2 and S_M1.
  - On exit from any of those states, phase_cycles <= counter+1 (cycles spent in that phase).
  - Saturates at all-ones; no wrap.
- Timeout: if the counter reaches TIMEOUT_CYCLES-1 in an active phase, set error=1, go to S_IDLE and set grant=3 the next cycle. The engine is not re-started.
- run: re-assertion while busy is ignored. A new decode requires run low in S_DISPLAY and then a new rising edge.

Test Plan:
- Nominal flow, SKIP_M2=0:
  - Stimulus: run rise; uart_done after 100 cycles; m2_endF 50 cycles after m2_startF; m1_endF 40 cycles after m1_startF.
  - Required: grant sequence 3,0,1,2,3; each start pulse exactly 1 cycle.
  - Required: phase_cycles = 100, then 50, then 40 at the respective phase exits.
- Mux and gap:
  - Stimulus: cli_addr[2]=18'd146944 and cli_we_n[2]=0 during S_GAP_B and S_M1.
  - Required: SRAM_we_n=1 in S_GAP_B; SRAM_address=146944 and SRAM_we_n=0 from S_M1_GO onward.
- SKIP_M2=1: required transitions S_UART -> S_GAP_A -> S_M1_GO; m2_startF never asserted; grant never 1.
- Spurious flags: pulse m1_endF during S_M2 and hold m2_endF high through S_M2_GO -> state stays in S_M2 until m2_endF is seen in S_M2, and S_M1 is not skipped.
- Timeout: TIMEOUT_CYCLES=64 with m1_endF never asserted -> error=1 and state=S_IDLE 64 cycles after S_M1 entry; next run rise clears error.
- Reset mid-S_M1: assert Reset one cycle -> next cycle state=S_IDLE, grant=3, SRAM_we_n=1, no start pulse, phase_cycles=0.
